// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch stage: widths, default reset PC,
// fetch-state encoding and small address helpers.
package rv32i_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential fetch address; wraps modulo 2^32
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer between fetch and decode: a shift-register FIFO whose
// slot 0 is the head, so the head fields come straight out of flops.
module fetch_buffer import rv32i_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    input  logic            flush,
    output logic [CW-1:0]   count,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    logic [XLEN-1:0] pc_r         [DEPTH];
    logic [XLEN-1:0] instr_r      [DEPTH];
    logic [XLEN-1:0] pc_next_s    [DEPTH];
    logic [XLEN-1:0] instr_next_s [DEPTH];
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic [CW-1:0]   wr_idx_s;
    logic            pop_s;
    logic            push_s;

    assign pop_s  = pop && (count_r != CW'(0));
    assign push_s = push && ((count_r < CW'(DEPTH)) || pop_s);

    // Storage next-state: shift toward the head on pop, then append on push
    always_comb begin
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        count_next_s = count_r;
        wr_idx_s     = count_r;
        if (flush) begin
            count_next_s = CW'(0);
        end else begin
            if (pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    pc_next_s[i]    = pc_r[i + 1];
                    instr_next_s[i] = instr_r[i + 1];
                end
                wr_idx_s = count_r - CW'(1);
            end else begin
                wr_idx_s = count_r;
            end
            for (int i = 0; i < DEPTH; i++) begin
                pc_next_s[i]    = (push_s && (wr_idx_s == CW'(i))) ? push_pc    : pc_next_s[i];
                instr_next_s[i] = (push_s && (wr_idx_s == CW'(i))) ? push_instr : instr_next_s[i];
            end
            count_next_s = count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]    <= '0;
                instr_r[i] <= '0;
            end
            count_r <= '0;
        end else begin
            pc_r    <= pc_next_s;
            instr_r <= instr_next_s;
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != CW'(0));
    assign head_pc    = pc_r[0];
    assign head_instr = instr_r[0];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem read channel,
// stale-response tracking across redirects, and the decode-side buffer.
module fetch_unit import rv32i_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t    state_r;
    fetch_state_t    state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] req_pc_r;
    logic [XLEN-1:0] req_pc_next_s;
    logic [CW-1:0]   count_s;
    logic            outstanding_s;
    logic            room_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic            head_valid_s;

    // DROP still owns a read in flight, so it occupies a buffer slot too
    assign outstanding_s = (state_r == WAIT) || (state_r == DROP);
    assign room_s        = ({1'b0, count_s} + (CW + 1)'(outstanding_s)) < DEPTH_W;
    assign pop_s         = head_valid_s && if_ready;

    // Fetch FSM next-state, request issue and pc update
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        req_pc_next_s = req_pc_r;
        req_valid_s   = 1'b0;
        accept_s      = 1'b0;
        push_s        = 1'b0;
        if (redirect_valid) begin
            pc_next_s = word_align(redirect_target);
            case (state_r)
                HOLD:    state_next_s = RUN;
                RUN:     state_next_s = RUN;
                WAIT:    state_next_s = imem_rsp_valid ? RUN : DROP;
                DROP:    state_next_s = imem_rsp_valid ? RUN : DROP;
                default: state_next_s = HOLD;
            endcase
        end else begin
            req_valid_s = (state_r != HOLD) && ((state_r == RUN) || imem_rsp_valid) && room_s;
            accept_s    = req_valid_s && imem_req_ready;
            if (accept_s) begin
                pc_next_s     = next_word(pc_r);
                req_pc_next_s = pc_r;
            end else begin
                pc_next_s     = pc_r;
                req_pc_next_s = req_pc_r;
            end
            case (state_r)
                HOLD:    state_next_s = RUN;
                RUN:     state_next_s = accept_s ? WAIT : RUN;
                WAIT: begin
                    push_s       = imem_rsp_valid;
                    state_next_s = (accept_s || !imem_rsp_valid) ? WAIT : RUN;
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_next_s = accept_s ? WAIT : RUN;
                    end else begin
                        state_next_s = DROP;
                    end
                end
                default: state_next_s = HOLD;
            endcase
        end
    end

    // FSM state, fetch pc and pc of the read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= HOLD;
            pc_r     <= word_align(RESET_PC);
            req_pc_r <= word_align(RESET_PC);
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            req_pc_r <= req_pc_next_s;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_pc    (req_pc_r),
        .push_instr (imem_rdata),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_r;
    assign if_valid       = head_valid_s;
    assign if_pc_plus4    = next_word(if_pc);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0/DEPTH 2 and RESET_PC
// 0xFFFF_FFFC/DEPTH 3) against a memory responder and a program-order stream model.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [0:1];
    logic        req_ready [0:1];
    logic [31:0] addr      [0:1];
    logic        rsp_valid [0:1];
    logic [31:0] rdata     [0:1];
    logic        redir     [0:1];
    logic [31:0] redir_tgt [0:1];
    logic        if_valid  [0:1];
    logic        if_ready  [0:1];
    logic [31:0] if_pc     [0:1];
    logic [31:0] if_p4     [0:1];
    logic [31:0] if_instr  [0:1];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid[0]), .imem_req_ready(req_ready[0]), .imem_addr(addr[0]),
        .imem_rsp_valid(rsp_valid[0]), .imem_rdata(rdata[0]),
        .redirect_valid(redir[0]), .redirect_target(redir_tgt[0]),
        .if_valid(if_valid[0]), .if_ready(if_ready[0]), .if_pc(if_pc[0]),
        .if_pc_plus4(if_p4[0]), .if_instr(if_instr[0])
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid[1]), .imem_req_ready(req_ready[1]), .imem_addr(addr[1]),
        .imem_rsp_valid(rsp_valid[1]), .imem_rdata(rdata[1]),
        .redirect_valid(redir[1]), .redirect_target(redir_tgt[1]),
        .if_valid(if_valid[1]), .if_ready(if_ready[1]), .if_pc(if_pc[1]),
        .if_pc_plus4(if_p4[1]), .if_instr(if_instr[1])
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] rpc  [0:1];
    logic [31:0] fexp [0:1];
    logic [31:0] dexp [0:1];
    logic [31:0] paddr[0:1];
    bit          pend [0:1];
    int          dly  [0:1];
    int          lat_min[0:1], lat_max[0:1], p_ready[0:1], p_ifr[0:1], p_redir[0:1];
    bit          dir_redir [0:1];
    logic [31:0] dir_tgt   [0:1];
    logic        s_req[0:1], s_ifv[0:1], s_acc[0:1], s_hs[0:1];
    logic [31:0] s_addr[0:1], s_ifpc[0:1], s_p4[0:1];
    int          acc_cnt[0:1], rsp_cnt[0:1], hs_cnt[0:1];

    typedef struct {
        logic        req0; logic [31:0] addr0; logic ifv0; logic [31:0] pc0;
        logic        req1; logic [31:0] addr1; logic ifv1; logic [31:0] pc1;
    } vec_t;
    vec_t tab [8];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0000_0013 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_knobs(input int i, input int lmin, input int lmax, input int prdy,
                             input int pifr, input int pred);
        lat_min[i] = lmin; lat_max[i] = lmax; p_ready[i] = prdy; p_ifr[i] = pifr; p_redir[i] = pred;
    endtask

    // One clock cycle: drive inputs, settle, check against the model, advance
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = pend[i] && (dly[i] == 0);
            rdata[i]     = rsp_valid[i] ? instr_of(paddr[i]) : $urandom();
            req_ready[i] = (int'($urandom_range(99)) < p_ready[i]);
            if_ready[i]  = (int'($urandom_range(99)) < p_ifr[i]);
            redir[i]     = dir_redir[i] || (int'($urandom_range(999)) < p_redir[i]);
            redir_tgt[i] = dir_redir[i] ? dir_tgt[i] : $urandom();
            dir_redir[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            s_req[i]  = req_valid[i];
            s_addr[i] = addr[i];
            s_ifv[i]  = if_valid[i];
            s_ifpc[i] = if_pc[i];
            s_p4[i]   = if_p4[i];
            s_acc[i]  = req_valid[i] && req_ready[i];
            s_hs[i]   = if_valid[i] && if_ready[i];
            if (redir[i]) chk("no_req_on_redirect", 32'(req_valid[i]), 32'd0);
            if (s_acc[i]) begin
                chk("one_outstanding", 32'(pend[i] && !rsp_valid[i]), 32'd0);
                chk("req_addr", addr[i], fexp[i]);
                fexp[i] = fexp[i] + 32'd4;
                acc_cnt[i]++;
            end
            if (s_hs[i]) begin
                chk("dec_pc", if_pc[i], dexp[i]);
                chk("dec_instr", if_instr[i], instr_of(dexp[i]));
                chk("dec_pc_plus4", if_p4[i], dexp[i] + 32'd4);
                dexp[i] = dexp[i] + 32'd4;
                hs_cnt[i]++;
            end
            if (redir[i]) begin
                fexp[i] = {redir_tgt[i][31:2], 2'b00};
                dexp[i] = {redir_tgt[i][31:2], 2'b00};
            end
            if (rsp_valid[i]) begin
                pend[i] = 1'b0;
                rsp_cnt[i]++;
            end else if (pend[i]) begin
                dly[i] = dly[i] - 1;
            end
            if (s_acc[i]) begin
                pend[i]  = 1'b1;
                paddr[i] = addr[i];
                dly[i]   = int'($urandom_range(lat_max[i], lat_min[i])) - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = 1'b0; rdata[i] = 32'd0; req_ready[i] = 1'b0;
            redir[i] = 1'b0; redir_tgt[i] = 32'd0; if_ready[i] = 1'b0;
            fexp[i] = rpc[i]; dexp[i] = rpc[i]; pend[i] = 1'b0; dly[i] = 0;
            dir_redir[i] = 1'b0; acc_cnt[i] = 0; rsp_cnt[i] = 0; hs_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int h0 [0:1];
        rpc[0] = 32'h0000_0000;
        rpc[1] = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) set_knobs(i, 1, 1, 100, 100, 0);

        // Asynchronous reset values, before any clock edge
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_ready[i] = 1'b0; rsp_valid[i] = 1'b0; rdata[i] = 32'd0;
            redir[i] = 1'b0; redir_tgt[i] = 32'd0; if_ready[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_valid", 32'(req_valid[i]), 32'd0);
            chk("rst_addr", addr[i], rpc[i]);
            chk("rst_if_valid", 32'(if_valid[i]), 32'd0);
            chk("rst_if_pc", if_pc[i], 32'd0);
            chk("rst_if_pc_plus4", if_p4[i], 32'd4);
            chk("rst_if_instr", if_instr[i], 32'd0);
        end

        // Cycle-exact trace: 1-cycle memory, decode always ready
        tab[0] = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0};
        tab[1] = '{1'b1, 32'h0,  1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        tab[2] = '{1'b1, 32'h4,  1'b0, 32'h0, 1'b1, 32'h0,         1'b0, 32'h0};
        tab[3] = '{1'b0, 32'h8,  1'b1, 32'h0, 1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC};
        tab[4] = '{1'b1, 32'h8,  1'b1, 32'h4, 1'b1, 32'h8,         1'b1, 32'h0};
        tab[5] = '{1'b1, 32'hC,  1'b0, 32'h0, 1'b1, 32'hC,         1'b1, 32'h4};
        tab[6] = '{1'b0, 32'h10, 1'b1, 32'h8, 1'b1, 32'h10,        1'b1, 32'h8};
        tab[7] = '{1'b1, 32'h10, 1'b1, 32'hC, 1'b1, 32'h14,        1'b1, 32'hC};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("tab%0d_req0", c), 32'(s_req[0]), 32'(tab[c].req0));
            chk($sformatf("tab%0d_addr0", c), s_addr[0], tab[c].addr0);
            chk($sformatf("tab%0d_ifv0", c), 32'(s_ifv[0]), 32'(tab[c].ifv0));
            if (tab[c].ifv0) chk($sformatf("tab%0d_pc0", c), s_ifpc[0], tab[c].pc0);
            chk($sformatf("tab%0d_req1", c), 32'(s_req[1]), 32'(tab[c].req1));
            chk($sformatf("tab%0d_addr1", c), s_addr[1], tab[c].addr1);
            chk($sformatf("tab%0d_ifv1", c), 32'(s_ifv[1]), 32'(tab[c].ifv1));
            if (tab[c].ifv1) begin
                chk($sformatf("tab%0d_pc1", c), s_ifpc[1], tab[c].pc1);
                chk($sformatf("tab%0d_p4_1", c), s_p4[1], tab[c].pc1 + 32'd4);
            end
        end

        // Decode stalled from reset: buffer fills, requests stop, then resume
        do_reset();
        set_knobs(0, 1, 1, 100, 0, 0);
        repeat (12) step();
        chk("stall_req_count", 32'(acc_cnt[0]), 32'd2);
        chk("stall_req_valid", 32'(s_req[0]), 32'd0);
        chk("stall_if_valid", 32'(s_ifv[0]), 32'd1);
        chk("stall_if_pc", s_ifpc[0], 32'h0);
        set_knobs(0, 1, 1, 100, 100, 0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (s_acc[0]) begin
                found = 1'b1;
                chk("resume_addr", s_addr[0], 32'h8);
            end
        end
        chk("resume_found", 32'(found), 32'd1);

        // Redirect while the read of 0x8 is still in flight
        do_reset();
        set_knobs(0, 3, 3, 100, 100, 0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = s_acc[0] && (s_addr[0] == 32'h8);
        end
        chk("drop_found_req8", 32'(found), 32'd1);
        dir_redir[0] = 1'b1;
        dir_tgt[0]   = 32'h0000_0100;
        step();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (s_hs[0]) begin
                found = 1'b1;
                chk("drop_first_pc", s_ifpc[0], 32'h100);
            end
        end
        chk("drop_found_hs", 32'(found), 32'd1);

        // Redirect to a misaligned target coinciding with a response
        do_reset();
        set_knobs(0, 1, 1, 100, 100, 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = s_acc[0] && (s_addr[0] == 32'hC);
        end
        chk("same_found_reqC", 32'(found), 32'd1);
        dir_redir[0] = 1'b1;
        dir_tgt[0]   = 32'h0000_0102;
        step();
        step();
        chk("same_flushed", 32'(s_ifv[0]), 32'd0);
        chk("same_req_valid", 32'(s_req[0]), 32'd1);
        chk("same_req_addr", s_addr[0], 32'h100);

        // Reset asserted while a read is outstanding with two entries buffered
        do_reset();
        for (int i = 0; i < 2; i++) set_knobs(i, 2, 2, 100, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = (acc_cnt[1] == 3) && (rsp_cnt[1] == 2) && pend[1];
        end
        chk("mid_found_wait2", 32'(found), 32'd1);
        chk("mid_pre_if_valid1", 32'(if_valid[1]), 32'd1);
        chk("mid_pre_if_valid0", 32'(if_valid[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("mid_if_valid", 32'(if_valid[i]), 32'd0);
            chk("mid_req_valid", 32'(req_valid[i]), 32'd0);
        end
        for (int i = 0; i < 2; i++) set_knobs(i, 1, 1, 100, 100, 0);
        do_reset();
        step();
        for (int i = 0; i < 2; i++) chk("mid_c0_req", 32'(s_req[i]), 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            chk("mid_c1_req", 32'(s_req[i]), 32'd1);
            chk("mid_c1_addr", s_addr[i], rpc[i]);
        end

        // Random traffic with redirects against the stream model
        do_reset();
        for (int i = 0; i < 2; i++) set_knobs(i, 1, 3, 70, 60, 40);
        repeat (3000) step();
        for (int i = 0; i < 2; i++) begin
            set_knobs(i, 1, 1, 100, 100, 0);
            h0[i] = hs_cnt[i];
        end
        repeat (40) step();
        for (int i = 0; i < 2; i++) chk("drain_progress", 32'(hs_cnt[i] - h0[i] >= 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. Holds the program counter, issues word-aligned instruction reads to instruction memory over a valid/ready request channel with one read outstanding, and buffers returned instructions with their PC in a small FIFO. The decode stage consumes from that FIFO. Control flow from execute (branch/jump target) arrives as a redirect that flushes the stage and restarts fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- DEPTH, 2, instruction buffer entries (≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  request address, bits [1:0] always 00
- imem_rsp_valid  in  1  read data valid; in order, ≥1 cycle after accept, never backpressured
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  one-cycle redirect pulse from execute
- redirect_target  in  32  new fetch address
- if_valid  out  1  buffer head valid
- if_ready  in  1  decode accepts head
- if_pc  out  32  PC of head instruction
- if_pc_plus4  out  32  if_pc + 4, mod 2^32
- if_instr  out  32  head instruction word

## Operation
- Registers: pc (next fetch address), FIFO of {pc, instr}, count (0..DEPTH), state.
- States: HOLD (first cycle after reset release; no request), RUN (none outstanding), WAIT (one outstanding, live), DROP (one outstanding, stale).
- Issue rule: imem_req_valid = !redirect_valid && state≠HOLD && (state==RUN || imem_rsp_valid) && (count + outstanding) < DEPTH, using registered count/outstanding.
- imem_addr = pc always. On accept: pc ← pc + 4 (32-bit wrap, 0xFFFF_FFFC → 0x0000_0000); state → WAIT.
- Response in WAIT: push {request pc, imem_rdata}; state → RUN unless a new request is accepted the same cycle (stays WAIT).
- Response in DROP: discarded; state → RUN or WAIT per same-cycle accept.
- Pop when if_valid && if_ready; push and pop in the same cycle leave count unchanged.
- Redirect (highest priority): FIFO flushed (count ← 0); pc ← {redirect_target[31:2], 2'b00}; no request that cycle; WAIT with no response this cycle → DROP; WAIT/DROP with response this cycle → response discarded, state → RUN; RUN stays RUN. A pop coinciding with redirect counts as a completed transfer.
- redirect_target[1:0] ignored; misalignment traps are decode/execute's concern.
- Transitions: HOLD→RUN unconditionally; RUN→WAIT on accept; WAIT→RUN/WAIT on response; WAIT→DROP on redirect without response; DROP→RUN/WAIT on response.

## Timing
- Reset values (async, immediate): imem_req_valid 0, imem_addr RESET_PC, pc RESET_PC, state HOLD, count 0, if_valid 0, if_pc 0, if_pc_plus4 4, if_instr 0.
- First request: second rising edge after rst_n deasserts (cycle 0 HOLD, cycle 1 request).
- Fetch-to-decode latency: instruction visible on if_* the cycle after imem_rsp_valid.
- Outputs if_* registered from FIFO head; stable while if_valid && !if_ready.
- Throughput with 1-cycle memory and decode always ready: 2 per 3 cycles at DEPTH=2; 1 per cycle at DEPTH≥3.
- Redirect at cycle t: first request to target at t+1.
- Reset mid-operation: outstanding read forgotten; memory is reset by the same rst_n.

## Structure
- Shared package rv32i_pkg: XLEN=32, INSTR_BYTES=4, default RESET_PC, fetch-state enum {HOLD, RUN, WAIT, DROP}.
- Sub-module fetch_buffer: DEPTH-entry synchronous FIFO of {pc, instr} with push, pop, flush, count, head outputs. FSM and pc logic remain in fetch_unit.

## Test plan
- Reset release, RESET_PC=0x0, 1-cycle memory returning 0x00000013+addr, if_ready=1 -> requests 0x0, 0x4, 0x8 starting cycle 1; if_pc 0x0, 0x4, 0x8 in order with matching if_instr; if_pc_plus4 = if_pc+4.
- if_ready=0 from reset -> exactly 2 requests (0x0, 0x4), then imem_req_valid stays 0; if_pc holds 0x0; releasing if_ready resumes at 0x8.
- Request 0x8 outstanding, redirect to 0x100 before response -> state DROP, response for 0x8 discarded, next if_pc 0x100; no instruction from 0x8 ever reaches decode.
- Redirect to 0x102 with response arriving the same cycle -> response dropped, FIFO empty, next request 0x100.
- RESET_PC=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000; if_pc_plus4 of first = 0x0000_0000.
- rst_n low while in WAIT with 2 entries buffered -> if_valid and imem_req_valid drop to 0 without a clock edge; after release, first request to RESET_PC on cycle 1.
